// File: rtl/coin_acceptor.sv
// Coin credit front end for the washing machine controller; issues coin_in/double_wash when paid, returns change.
// Optional idle-collection refund timeout is built when COIN_TIMEOUT_EN is defined.
module coin_acceptor #(
    parameter int CREDIT_W       = 8,
    parameter int PRICE_SINGLE   = 4,
    parameter int PRICE_DOUBLE   = 6,
    parameter int MAX_CREDIT     = 200,
    parameter int TIMEOUT_CYCLES = 60000000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                coin_valid,
    input  logic [1:0]          coin_value,
    input  logic                wash_sel,
    input  logic                cancel,
    input  logic                wash_done,
    output logic                coin_in,
    output logic                double_wash,
    output logic [CREDIT_W-1:0] credit,
    output logic                change_valid,
    output logic [CREDIT_W-1:0] change_amount,
    output logic                coin_reject,
    output logic                busy
);

    typedef enum logic [1:0] {IDLE, COLLECT, START, RUNNING} state_t;

    state_t              state;
    logic                wd_q;
    logic [CREDIT_W-1:0] price;
    logic [CREDIT_W-1:0] coin_amt;
    logic [CREDIT_W:0]   sum;
    logic                coin_ok;
    logic                paid;
    logic                tmo_hit;

    always_comb begin
        price = wash_sel ? CREDIT_W'(PRICE_DOUBLE) : CREDIT_W'(PRICE_SINGLE);
        case (coin_value)
            2'b00:   coin_amt = CREDIT_W'(1);
            2'b01:   coin_amt = CREDIT_W'(2);
            2'b10:   coin_amt = CREDIT_W'(5);
            default: coin_amt = CREDIT_W'(10);
        endcase
        sum     = {1'b0, credit} + {1'b0, coin_amt};
        coin_ok = (sum <= (CREDIT_W+1)'(MAX_CREDIT));
        paid    = (credit >= price);
    end

`ifdef COIN_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [TW-1:0] tmo_cnt;

    // Fires one cycle ahead so the registered refund lands TIMEOUT_CYCLES after the last coin.
    assign tmo_hit = (state == COLLECT) && (tmo_cnt == TW'(TIMEOUT_CYCLES - 2));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt <= '0;
        end else if (state == COLLECT && !cancel && !paid && !tmo_hit
                     && !(coin_valid && coin_ok)) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end else begin
            tmo_cnt <= '0;
        end
    end
`else
    logic unused_cfg;
    assign unused_cfg = ^TIMEOUT_CYCLES;
    assign tmo_hit    = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            wd_q          <= 1'b0;
            credit        <= '0;
            coin_in       <= 1'b0;
            double_wash   <= 1'b0;
            change_valid  <= 1'b0;
            change_amount <= '0;
            coin_reject   <= 1'b0;
            busy          <= 1'b0;
        end else begin
            wd_q          <= wash_done;
            coin_in       <= 1'b0;
            change_valid  <= 1'b0;
            change_amount <= '0;
            coin_reject   <= 1'b0;
            case (state)
                IDLE: begin
                    if (coin_valid) begin
                        if (coin_ok) begin
                            credit <= coin_amt;
                            state  <= COLLECT;
                        end else begin
                            coin_reject <= 1'b1;
                        end
                    end
                end
                COLLECT: begin
                    if (cancel) begin
                        // A coin accepted alongside cancel is refunded with the rest.
                        change_valid  <= 1'b1;
                        change_amount <= (coin_valid && coin_ok) ? sum[CREDIT_W-1:0] : credit;
                        coin_reject   <= coin_valid && !coin_ok;
                        credit        <= '0;
                        state         <= IDLE;
                    end else if (paid) begin
                        coin_in     <= 1'b1;
                        double_wash <= wash_sel;
                        busy        <= 1'b1;
                        coin_reject <= coin_valid;
                        state       <= START;
                        if (credit > price) begin
                            change_valid  <= 1'b1;
                            change_amount <= credit - price;
                        end
                    end else if (coin_valid && coin_ok) begin
                        credit <= sum[CREDIT_W-1:0];
                    end else begin
                        coin_reject <= coin_valid;
                        if (tmo_hit) begin
                            change_valid  <= 1'b1;
                            change_amount <= credit;
                            credit        <= '0;
                            state         <= IDLE;
                        end
                    end
                end
                START: begin
                    coin_reject <= coin_valid;
                    credit      <= '0;
                    state       <= RUNNING;
                end
                RUNNING: begin
                    coin_reject <= coin_valid;
                    // Only a fresh rising edge ends the wash; a level already high on entry is ignored.
                    if (wash_done && !wd_q) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_coin_acceptor.sv
// Scoreboard bench for coin_acceptor: a default-price instance (short timeout) and a low-ceiling saturation instance.
module tb_coin_acceptor;

    typedef struct packed {
        logic [1:0]  kind;  // 0 reject, 1 coin_in, 2 change
        int unsigned cyc;
        logic [7:0]  val;
    } evt_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic       coin_valid, wash_sel, cancel, wash_done;
    logic [1:0] coin_value;
    logic       coin_in, double_wash, change_valid, coin_reject, busy;
    logic [7:0] credit, change_amount;

    logic       s_coin_valid, s_wash_sel, s_cancel;
    logic [1:0] s_coin_value;
    logic       s_coin_in, s_double_wash, s_change_valid, s_coin_reject, s_busy;
    logic [7:0] s_credit, s_change_amount;

    coin_acceptor #(.TIMEOUT_CYCLES(16)) u_dut (
        .clk(clk), .rst(rst), .coin_valid(coin_valid), .coin_value(coin_value),
        .wash_sel(wash_sel), .cancel(cancel), .wash_done(wash_done),
        .coin_in(coin_in), .double_wash(double_wash), .credit(credit),
        .change_valid(change_valid), .change_amount(change_amount),
        .coin_reject(coin_reject), .busy(busy)
    );

    coin_acceptor #(.MAX_CREDIT(12), .PRICE_DOUBLE(20)) u_sat (
        .clk(clk), .rst(rst), .coin_valid(s_coin_valid), .coin_value(s_coin_value),
        .wash_sel(s_wash_sel), .cancel(s_cancel), .wash_done(wash_done),
        .coin_in(s_coin_in), .double_wash(s_double_wash), .credit(s_credit),
        .change_valid(s_change_valid), .change_amount(s_change_amount),
        .coin_reject(s_coin_reject), .busy(s_busy)
    );

    evt_t q0[$];
    evt_t q1[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic expect_evt(input int d, input logic [1:0] k, input int unsigned c, input logic [7:0] v);
        evt_t e;
        e.kind = k;
        e.cyc  = c;
        e.val  = v;
        if (d == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    task automatic mon(input int d, input logic [1:0] k, input logic [7:0] v);
        evt_t e;
        n_cmp++;
        if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
            n_bad++;
            $display("FAIL evt_unexpected dut%0d kind=%0d val=%0d cyc=%0d (none required)", d, k, v, cyc);
        end else begin
            e = (d == 0) ? q0.pop_front() : q1.pop_front();
            if (e.kind !== k || e.cyc != cyc || e.val !== v) begin
                n_bad++;
                $display("FAIL evt dut%0d got kind=%0d cyc=%0d val=%0d, required kind=%0d cyc=%0d val=%0d",
                         d, k, cyc, v, e.kind, e.cyc, e.val);
            end
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s got %0d required %0d (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (coin_reject)  mon(0, 2'd0, 8'd0);
            if (coin_in)      mon(0, 2'd1, {7'd0, double_wash});
            if (change_valid) mon(0, 2'd2, change_amount);
            else if (change_amount != 0) chk("idle_change_amount", change_amount, 0);
            if (s_coin_reject)  mon(1, 2'd0, 8'd0);
            if (s_coin_in)      mon(1, 2'd1, {7'd0, s_double_wash});
            if (s_change_valid) mon(1, 2'd2, s_change_amount);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic coin(input logic [1:0] v, output int unsigned n);
        coin_valid = 1'b1;
        coin_value = v;
        n = cyc;
        tick();
        coin_valid = 1'b0;
    endtask

    initial begin
        int unsigned a, b, c;
        coin_valid = 0; coin_value = 0; wash_sel = 0; cancel = 0; wash_done = 0;
        s_coin_valid = 0; s_coin_value = 0; s_wash_sel = 0; s_cancel = 0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        tick();

        // Reset state
        chk("rst_credit", credit, 0);
        chk("rst_busy", busy, 0);
        chk("rst_double_wash", double_wash, 0);
        chk("rst_coin_in", coin_in, 0);
        chk("rst_sat_credit", s_credit, 0);

        // Single exact payment: 2 + 2 = 4
        coin(2'b01, a);
        chk("single_credit_2", credit, 2);
        coin(2'b01, b);
        expect_evt(0, 2'd1, b + 2, 8'd0);
        chk("single_credit_4", credit, 4);
        tick();
        chk("single_busy_start", busy, 1);
        chk("single_double_wash", double_wash, 0);
        tick();
        chk("single_credit_cleared", credit, 0);
        wash_done = 1'b1;
        tick();
        chk("single_idle_after_done", busy, 0);
        wash_done = 1'b0;
        tick();

        // Overpay double wash, then busy rejection and wash_done edge handling
        wash_sel = 1'b1;
        coin(2'b10, a);
        coin(2'b10, b);
        expect_evt(0, 2'd1, b + 2, 8'd1);
        expect_evt(0, 2'd2, b + 2, 8'd4);
        chk("double_credit_10", credit, 10);
        tick();
        wash_done = 1'b1;
        chk("double_busy_start", busy, 1);
        tick();
        chk("double_credit_cleared", credit, 0);
        coin(2'b11, c);
        expect_evt(0, 2'd0, c + 1, 8'd0);
        chk("busy_reject_credit", credit, 0);
        tick();
        tick();
        chk("held_done_not_edge", busy, 1);
        wash_done = 1'b0;
        tick();
        tick();
        chk("done_low_still_busy", busy, 1);
        wash_done = 1'b1;
        tick();
        chk("done_rise_idle", busy, 0);
        chk("double_wash_held", double_wash, 1);
        wash_done = 1'b0;
        wash_sel = 1'b0;
        tick();

        // Cancel with a simultaneous coin: 3 + 2 refunded
        coin(2'b00, a);
        coin(2'b01, b);
        chk("cancel_credit_3", credit, 3);
        cancel = 1'b1;
        coin(2'b01, c);
        cancel = 1'b0;
        expect_evt(0, 2'd2, c + 1, 8'd5);
        chk("cancel_credit_0", credit, 0);
        chk("cancel_not_busy", busy, 0);
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        tick();
        tick();
        chk("idle_cancel_credit", credit, 0);

        // Cancel beats reaching the price in the same cycle
        coin(2'b01, a);
        coin(2'b01, b);
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        expect_evt(0, 2'd2, b + 2, 8'd4);
        chk("cancel_wins_busy", busy, 0);
        chk("cancel_wins_credit", credit, 0);
        tick();

        // Reset mid-wash: nothing refunded
        coin(2'b11, a);
        expect_evt(0, 2'd1, a + 2, 8'd0);
        expect_evt(0, 2'd2, a + 2, 8'd6);
        tick();
        tick();
        chk("midwash_busy", busy, 1);
        rst = 1'b1;
        #2;
        chk("midwash_rst_busy", busy, 0);
        chk("midwash_rst_credit", credit, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        tick();

        // Saturation on the low-ceiling instance
        s_wash_sel = 1'b1;
        s_coin_valid = 1'b1;
        s_coin_value = 2'b11;
        tick();
        s_coin_value = 2'b10;
        a = cyc;
        tick();
        s_coin_valid = 1'b0;
        expect_evt(1, 2'd0, a + 1, 8'd0);
        chk("sat_credit_10", s_credit, 10);
        s_cancel = 1'b1;
        tick();
        s_cancel = 1'b0;
        expect_evt(1, 2'd2, a + 2, 8'd10);
        chk("sat_credit_0", s_credit, 0);
        tick();

        // Idle-collection timeout
        coin(2'b00, a);
`ifdef COIN_TIMEOUT_EN
        expect_evt(0, 2'd2, a + 16, 8'd1);
        repeat (16) tick();
        chk("timeout_credit", credit, 0);
        chk("timeout_busy", busy, 0);
`else
        repeat (20) tick();
        chk("no_timeout_credit", credit, 1);
        cancel = 1'b1;
        c = cyc;
        tick();
        cancel = 1'b0;
        expect_evt(0, 2'd2, c + 1, 8'd1);
`endif
        repeat (3) tick();

        chk("leftover_main", q0.size(), 0);
        chk("leftover_sat", q1.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/coin_acceptor.md
Name: coin_acceptor

Overview:
- Payment front end directly upstream of washing_machine_controller.
- Accumulates coin credit and compares it against the single or double wash price.
- When credit covers the price, issues the one-cycle coin_in start pulse and the held double_wash level to the controller, and returns any excess as change.
- Blocks new payment while a wash runs; unblocks on the controller's wash_done.

Parameters:
- CREDIT_W, 8, credit register width.
- PRICE_SINGLE, 4, credit units for a single wash.
- PRICE_DOUBLE, 6, credit units for a double wash.
- MAX_CREDIT, 200, saturation ceiling for credit; must be < 2^CREDIT_W.
- TIMEOUT_CYCLES, 60000000, idle-collection timeout. Used only with COIN_TIMEOUT_EN.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- coin_valid  input  1  one-cycle pulse: a coin was inserted. Consecutive-cycle pulses are separate coins.
- coin_value  input  2  denomination, sampled with coin_valid: 00=1, 01=2, 10=5, 11=10 units.
- wash_sel  input  1  1 = double wash requested. Sampled every cycle in COLLECT.
- cancel  input  1  one-cycle pulse: refund request.
- wash_done  input  1  level from the controller; high when a wash has finished.
- coin_in  output  1  one-cycle start pulse to the controller.
- double_wash  output  1  latched wash_sel. Held from the START cycle until the next START.
- credit  output  CREDIT_W  current accumulated credit.
- change_valid  output  1  one-cycle pulse; change_amount is valid in that cycle.
- change_amount  output  CREDIT_W  refund or change value.
- coin_reject  output  1  one-cycle pulse: the coin in this cycle was not accepted.
- busy  output  1  high in START and RUNNING.

Behaviour:
- Reset (async, rst=1): state IDLE; all outputs 0; wash_done edge register = 0; timeout counter = 0.
- Price: price = wash_sel ? PRICE_DOUBLE : PRICE_SINGLE, evaluated combinationally each cycle.
- IDLE (credit = 0):
  - coin_valid: credit <= value, go to COLLECT.
  - cancel: ignored (no change pulse).
- COLLECT:
  - coin_valid adds value to credit.
  - If credit + value > MAX_CREDIT: credit unchanged and coin_reject = 1 the next cycle.
  - Each cycle, if registered credit >= price: go to START.
- START (exactly one cycle):
  - coin_in = 1.
  - double_wash <= wash_sel.
  - If credit > price: change_valid = 1 and change_amount = credit - price, in the same cycle.
  - credit <= 0; next state RUNNING.
  - Latency: coin that completes payment at cycle N → coin_in at cycle N+2.
- RUNNING:
  - wait for a rising edge of wash_done (registered previous value 0, current 1), then go to IDLE.
  - A wash_done already high on entry is not an edge; the block waits for it to fall and rise again.
- Cancel in COLLECT:
  - change_valid = 1 next cycle, change_amount = credit, including any coin accepted in the same cycle as cancel.
  - credit <= 0; go to IDLE.
- Simultaneous events:
  - cancel wins over reaching the price in the same cycle.
  - coin_valid during START or RUNNING → coin_reject pulse, credit unaffected.
  - cancel during START or RUNNING is ignored.
- change_amount holds 0 when change_valid = 0.
- Reset mid-wash: credit is lost and no refund is issued. The bench must not expect change after reset.

Optional Feature:
- Macro: COIN_TIMEOUT_EN.
- Enabled:
  - A counter runs in COLLECT and clears on every accepted coin.
  - On reaching TIMEOUT_CYCLES-1, the block refunds the full credit (same as cancel) and returns to IDLE.
  - The counter is 0 outside COLLECT.
- Disabled: no counter logic; COLLECT waits indefinitely.

Test Plan:
- Single exact payment: wash_sel=0; coins 2,2 → credit 2 then 4; coin_in pulse 2 cycles after the second coin; double_wash=0; change_valid never asserted; busy=1.
- Overpay double: wash_sel=1; coins 5,5 → START with coin_in=1, change_valid=1, change_amount=4, double_wash=1; credit=0 afterwards.
- Cancel with simultaneous coin: credit 3; cancel and coin_value=01 in the same cycle → change_amount=5, state IDLE, no coin_in.
- Busy rejection: during RUNNING inject coin 10 → coin_reject=1, credit stays 0. Hold wash_done high from START, drop it, raise it → return to IDLE only on the rise.
- Saturation: MAX_CREDIT=12, wash_sel=1 held with PRICE_DOUBLE=20; coins 10 then 5 → second coin rejected, credit=10; cancel → change_amount=10.
- COIN_TIMEOUT_EN with TIMEOUT_CYCLES=16: single coin 1 then idle → change_valid with change_amount=1 exactly 16 cycles after the coin; state IDLE. Without the macro, credit stays 1.
